// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream mux with one registered output stage; sel-driven or round-robin grant.
// Latency 1 cycle; while the output word is stalled all in_ready drop and the output holds.
module stream_mux_n #(
   parameter int WIDTH = 3,
   parameter int N     = 3,
   parameter int SEL_W = 2,
   parameter int RR    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   out_chan,
   output logic               err_sel
);

   logic [SEL_W-1:0] gnt;
   logic [SEL_W-1:0] rr_ptr;
   logic             gnt_vld;
   logic             sel_bad;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] gnt_data;

   // The output register can take a word when empty or when its word leaves this edge.
   assign load = !out_valid || out_ready;
   assign xfer = load && gnt_vld;

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      sel_bad = 1'b0;
      if (RR == 0) begin
         sel_bad = (int'(sel) >= N);
         for (int i = 0; i < N; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               gnt     = SEL_W'(i);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         // Walk from the far end back to rr_ptr so the nearest requester wins.
         for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[(int'(rr_ptr) + k) % N]) begin
               gnt     = SEL_W'((int'(rr_ptr) + k) % N);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt == SEL_W'(i)) begin
            gnt_data    = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = xfer;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         err_sel   <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         err_sel <= (RR == 0) && load && sel_bad;
         if (load) begin
            out_valid <= xfer;
            if (xfer) begin
               out_data <= gnt_data;
               out_chan <= gnt;
            end
         end
         if (RR != 0 && xfer) begin
            rr_ptr <= (gnt == SEL_W'(N - 1)) ? '0 : gnt + SEL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: one sel-driven instance and one round-robin instance.
module tb_stream_mux_n;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [8:0] a_data = '0;
   logic [2:0] a_valid = '0;
   logic [2:0] a_ready;
   logic [1:0] a_sel = '0;
   logic [2:0] a_odata;
   logic       a_ovalid;
   logic       a_ordy = 1'b0;
   logic [1:0] a_chan;
   logic       a_err;

   logic [8:0] b_data = '0;
   logic [2:0] b_valid = '0;
   logic [2:0] b_ready;
   logic [1:0] b_sel = '0;
   logic [2:0] b_odata;
   logic       b_ovalid;
   logic       b_ordy = 1'b0;
   logic [1:0] b_chan;
   logic       b_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stream_mux_n #(.WIDTH(3), .N(3), .SEL_W(2), .RR(0)) u_sel (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_ordy),
      .out_chan(a_chan), .err_sel(a_err));

   stream_mux_n #(.WIDTH(3), .N(3), .SEL_W(2), .RR(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_ordy),
      .out_chan(b_chan), .err_sel(b_err));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      tests++; if (a_ovalid !== 1'b0) begin fails++; $display("FAIL rst_a_ovalid got=%b exp=0", a_ovalid); end
      tests++; if (a_odata !== 3'd0) begin fails++; $display("FAIL rst_a_odata got=%h exp=0", a_odata); end
      tests++; if (a_chan !== 2'd0) begin fails++; $display("FAIL rst_a_chan got=%h exp=0", a_chan); end
      tests++; if (a_err !== 1'b0) begin fails++; $display("FAIL rst_a_err got=%b exp=0", a_err); end
      tests++; if (b_ovalid !== 1'b0) begin fails++; $display("FAIL rst_b_ovalid got=%b exp=0", b_ovalid); end
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sel_basic();
      a_data  = 9'b000_101_000;
      a_sel   = 2'd1;
      a_valid = 3'b010;
      a_ordy  = 1'b1;
      #1;
      tests++; if (a_ready !== 3'b010) begin fails++; $display("FAIL t1_in_ready got=%b exp=010", a_ready); end
      tick();
      tests++; if (a_ovalid !== 1'b1) begin fails++; $display("FAIL t1_ovalid got=%b exp=1", a_ovalid); end
      tests++; if (a_odata !== 3'h5) begin fails++; $display("FAIL t1_odata got=%h exp=5", a_odata); end
      tests++; if (a_chan !== 2'd1) begin fails++; $display("FAIL t1_chan got=%h exp=1", a_chan); end
      a_valid = 3'b000;
      #1;
      tests++; if (a_ready !== 3'b000) begin fails++; $display("FAIL t1_idle_ready got=%b exp=000", a_ready); end
      tick();
      tests++; if (a_ovalid !== 1'b0) begin fails++; $display("FAIL t1_idle_ovalid got=%b exp=0", a_ovalid); end
      tests++; if (a_odata !== 3'h5) begin fails++; $display("FAIL t1_hold_odata got=%h exp=5", a_odata); end
   endtask

   task automatic test_sel_err();
      a_data  = 9'b111_010_100;
      a_valid = 3'b111;
      a_sel   = 2'd2;
      tick();
      tests++; if (a_chan !== 2'd2 || a_odata !== 3'h7) begin fails++; $display("FAIL t2_pre chan=%h data=%h exp chan=2 data=7", a_chan, a_odata); end
      a_sel = 2'd3;
      #1;
      tests++; if (a_ready !== 3'b000) begin fails++; $display("FAIL t2_in_ready got=%b exp=000", a_ready); end
      tick();
      tests++; if (a_err !== 1'b1) begin fails++; $display("FAIL t2_err got=%b exp=1", a_err); end
      tests++; if (a_ovalid !== 1'b0) begin fails++; $display("FAIL t2_ovalid got=%b exp=0", a_ovalid); end
      a_sel = 2'd0;
      tick();
      tests++; if (a_err !== 1'b0) begin fails++; $display("FAIL t2_err_clear got=%b exp=0", a_err); end
      tests++; if (a_ovalid !== 1'b1 || a_chan !== 2'd0 || a_odata !== 3'h4) begin fails++; $display("FAIL t2_recover v=%b chan=%h data=%h exp v=1 chan=0 data=4", a_ovalid, a_chan, a_odata); end
   endtask

   task automatic test_backpressure();
      a_data  = 9'b000_000_011;
      a_valid = 3'b001;
      a_sel   = 2'd0;
      tick();
      tests++; if (a_odata !== 3'h3 || a_chan !== 2'd0) begin fails++; $display("FAIL t3_load data=%h chan=%h exp data=3 chan=0", a_odata, a_chan); end
      a_ordy  = 1'b0;
      a_data  = 9'b001_110_010;
      a_valid = 3'b111;
      a_sel   = 2'd1;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) a_sel = 2'd3;
         if (c == 3) a_sel = 2'd1;
         #1;
         tests++; if (a_ready !== 3'b000) begin fails++; $display("FAIL t3_ready_c%0d got=%b exp=000", c, a_ready); end
         tick();
         tests++; if (a_ovalid !== 1'b1 || a_odata !== 3'h3 || a_chan !== 2'd0) begin fails++; $display("FAIL t3_hold_c%0d v=%b data=%h chan=%h exp v=1 data=3 chan=0", c, a_ovalid, a_odata, a_chan); end
      end
      tests++; if (a_err !== 1'b0) begin fails++; $display("FAIL t3_err_stalled got=%b exp=0", a_err); end
      a_ordy = 1'b1;
      #1;
      tests++; if (a_ready !== 3'b010) begin fails++; $display("FAIL t3_release_ready got=%b exp=010", a_ready); end
      tick();
      tests++; if (a_ovalid !== 1'b1 || a_odata !== 3'h6 || a_chan !== 2'd1) begin fails++; $display("FAIL t3_next v=%b data=%h chan=%h exp v=1 data=6 chan=1", a_ovalid, a_odata, a_chan); end
      a_valid = 3'b000;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      logic [1:0] exp_ch  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      logic [2:0] exp_dat [6] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
      b_data  = {3'd3, 3'd2, 3'd1};
      b_valid = 3'b111;
      b_ordy  = 1'b1;
      b_sel   = 2'd3;
      for (int k = 0; k < 6; k++) begin
         #1;
         tests++; if (b_ready !== exp_rdy[k]) begin fails++; $display("FAIL t4_ready_%0d got=%b exp=%b", k, b_ready, exp_rdy[k]); end
         tick();
         tests++; if (b_ovalid !== 1'b1 || b_chan !== exp_ch[k] || b_odata !== exp_dat[k]) begin fails++; $display("FAIL t4_out_%0d v=%b chan=%h data=%h exp chan=%h data=%h", k, b_ovalid, b_chan, b_odata, exp_ch[k], exp_dat[k]); end
      end
      tests++; if (b_err !== 1'b0) begin fails++; $display("FAIL t4_err got=%b exp=0", b_err); end
      #1;
      tests++; if (b_ready !== 3'b001) begin fails++; $display("FAIL t4_g0 got=%b exp=001", b_ready); end
      tick();
      b_valid = 3'b101;
      #1;
      tests++; if (b_ready !== 3'b100) begin fails++; $display("FAIL t4_skip1 got=%b exp=100", b_ready); end
      tick();
      tests++; if (b_chan !== 2'd2 || b_odata !== 3'd3) begin fails++; $display("FAIL t4_skip1_out chan=%h data=%h exp chan=2 data=3", b_chan, b_odata); end
      #1;
      tests++; if (b_ready !== 3'b001) begin fails++; $display("FAIL t4_wrap got=%b exp=001", b_ready); end
      tick();
      tests++; if (b_chan !== 2'd0 || b_odata !== 3'd1) begin fails++; $display("FAIL t4_wrap_out chan=%h data=%h exp chan=0 data=1", b_chan, b_odata); end
   endtask

   task automatic test_async_reset();
      b_valid = 3'b111;
      tick();
      tests++; if (b_chan !== 2'd1 || b_ovalid !== 1'b1) begin fails++; $display("FAIL t5_pre chan=%h v=%b exp chan=1 v=1", b_chan, b_ovalid); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (b_ovalid !== 1'b0 || b_odata !== 3'd0 || b_chan !== 2'd0) begin fails++; $display("FAIL t5_async v=%b data=%h chan=%h exp all 0", b_ovalid, b_odata, b_chan); end
      tests++; if (a_ovalid !== 1'b0 || a_odata !== 3'd0) begin fails++; $display("FAIL t5_async_a v=%b data=%h exp 0", a_ovalid, a_odata); end
      tick();
      #3 rst_n = 1'b1;
      #1;
      tests++; if (b_ready !== 3'b001) begin fails++; $display("FAIL t5_first_grant got=%b exp=001", b_ready); end
      tick();
      tests++; if (b_ovalid !== 1'b1 || b_chan !== 2'd0 || b_odata !== 3'd1) begin fails++; $display("FAIL t5_first_out v=%b chan=%h data=%h exp v=1 chan=0 data=1", b_ovalid, b_chan, b_odata); end
   endtask

   initial begin
      test_reset();
      test_sel_basic();
      test_sel_err();
      test_backpressure();
      test_round_robin();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
